// File: rtl/hp_arbiter_seq.sv
// rtl/hp_arbiter_seq.sv - round-robin HP update sequencer with saturating damage/heal
// Requests run IDLE -> CALC -> WRITE; a zero HP write parks the sequencer in HALT.
module hp_arbiter_seq #(
    parameter int HP_W      = 8,
    parameter int P_MAX_HP  = 100,
    parameter int AI_MAX_HP = 100
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            load_hp,
    input  logic            p_req,
    input  logic            p_op,
    input  logic [HP_W-1:0] p_amt,
    output logic            p_ack,
    input  logic            ai_req,
    input  logic            ai_op,
    input  logic [HP_W-1:0] ai_amt,
    output logic            ai_ack,
    output logic [HP_W-1:0] p_hp,
    output logic [HP_W-1:0] ai_hp,
    output logic            p_dead,
    output logic            ai_dead,
    output logic            busy
);

    typedef enum logic [1:0] {IDLE, CALC, WRITE, HALT} state_t;

    localparam logic [HP_W-1:0] P_MAX  = HP_W'(P_MAX_HP);
    localparam logic [HP_W-1:0] AI_MAX = HP_W'(AI_MAX_HP);

    state_t          state;
    logic            lat_id;      // 0 = player, 1 = AI
    logic            lat_op;
    logic [HP_W-1:0] lat_amt;
    logic [HP_W-1:0] hold;
    logic            last_grant;  // 0 = player, 1 = AI

    logic            grant_ai;
    logic            tgt_ai;
    logic [HP_W-1:0] old_hp;
    logic [HP_W-1:0] max_hp;
    logic [HP_W:0]   sum;
    logic [HP_W-1:0] new_val;

    // AI wins when it requests alone, or on a tie when the player was granted last
    assign grant_ai = ai_req && (!p_req || !last_grant);

    // Damage hits the opponent, heal hits the requester itself
    assign tgt_ai = ~(lat_id ^ lat_op);
    assign old_hp = tgt_ai ? ai_hp : p_hp;
    assign max_hp = tgt_ai ? AI_MAX : P_MAX;
    assign sum    = {1'b0, old_hp} + {1'b0, lat_amt};

    always_comb begin
        new_val = '0;
        if (lat_op) begin
            new_val = (sum > {1'b0, max_hp}) ? max_hp : sum[HP_W-1:0];
        end else if (lat_amt < old_hp) begin
            new_val = old_hp - lat_amt;
        end
    end

    assign busy   = (state != IDLE);
    assign p_ack  = (state == WRITE) && !lat_id && !load_hp;
    assign ai_ack = (state == WRITE) &&  lat_id && !load_hp;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            lat_id     <= 1'b0;
            lat_op     <= 1'b0;
            lat_amt    <= '0;
            hold       <= '0;
            last_grant <= 1'b1;
            p_hp       <= P_MAX;
            ai_hp      <= AI_MAX;
            p_dead     <= 1'b0;
            ai_dead    <= 1'b0;
        end else if (load_hp) begin
            state   <= IDLE;
            p_hp    <= P_MAX;
            ai_hp   <= AI_MAX;
            p_dead  <= 1'b0;
            ai_dead <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (p_req || ai_req) begin
                        lat_id  <= grant_ai;
                        lat_op  <= grant_ai ? ai_op  : p_op;
                        lat_amt <= grant_ai ? ai_amt : p_amt;
                        state   <= CALC;
                    end
                end
                CALC: begin
                    hold  <= new_val;
                    state <= WRITE;
                end
                WRITE: begin
                    last_grant <= lat_id;
                    if (tgt_ai) ai_hp <= hold;
                    else        p_hp  <= hold;
                    if (hold == '0) begin
                        if (tgt_ai) ai_dead <= 1'b1;
                        else        p_dead  <= 1'b1;
                        state <= HALT;
                    end else begin
                        state <= IDLE;
                    end
                end
                default: state <= HALT;
            endcase
        end
    end

endmodule

// File: tb/tb_hp_arbiter_seq.sv
// tb/tb_hp_arbiter_seq.sv - directed self-checking bench for hp_arbiter_seq
module tb_hp_arbiter_seq;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       load_hp = 1'b0;
    logic       p_req = 1'b0, p_op = 1'b0, ai_req = 1'b0, ai_op = 1'b0;
    logic [7:0] p_amt = '0, ai_amt = '0;
    logic       p_ack, ai_ack, p_dead, ai_dead, busy;
    logic [7:0] p_hp, ai_hp;

    int checks = 0;
    int failures = 0;

    hp_arbiter_seq #(.HP_W(8), .P_MAX_HP(100), .AI_MAX_HP(100)) dut (
        .clk(clk), .reset(reset), .load_hp(load_hp),
        .p_req(p_req), .p_op(p_op), .p_amt(p_amt), .p_ack(p_ack),
        .ai_req(ai_req), .ai_op(ai_op), .ai_amt(ai_amt), .ai_ack(ai_ack),
        .p_hp(p_hp), .ai_hp(ai_hp), .p_dead(p_dead), .ai_dead(ai_dead), .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Runs one request to completion (bounded); returns with the commit visible
    task automatic run_op(input bit id, input bit op, input logic [7:0] amt, output bit acked);
        acked = 1'b0;
        if (!id) begin p_req = 1'b1; p_op = op; p_amt = amt; end
        else     begin ai_req = 1'b1; ai_op = op; ai_amt = amt; end
        for (int i = 0; i < 8 && !acked; i++) begin
            step();
            if (id ? ai_ack : p_ack) acked = 1'b1;
        end
        p_req = 1'b0;
        ai_req = 1'b0;
        step();
    endtask

    task automatic test_reset();
        reset = 1'b1;
        step();
        step();
        checks++; if (p_hp !== 8'd100)  begin failures++; $display("FAIL reset_p_hp got=%0d exp=100", p_hp); end
        checks++; if (ai_hp !== 8'd100) begin failures++; $display("FAIL reset_ai_hp got=%0d exp=100", ai_hp); end
        checks++; if ({p_dead, ai_dead, p_ack, ai_ack, busy} !== 5'b0)
            begin failures++; $display("FAIL reset_flags got=%b exp=00000", {p_dead, ai_dead, p_ack, ai_ack, busy}); end
        reset = 1'b0;
        step();
    endtask

    task automatic test_damage();
        p_req = 1'b1; p_op = 1'b0; p_amt = 8'd30;
        step();
        checks++; if ({busy, p_ack} !== 2'b10) begin failures++; $display("FAIL dmg_calc busy,ack got=%b exp=10", {busy, p_ack}); end
        step();
        checks++; if ({busy, p_ack, ai_ack} !== 3'b110) begin failures++; $display("FAIL dmg_write busy,p_ack,ai_ack got=%b exp=110", {busy, p_ack, ai_ack}); end
        checks++; if (ai_hp !== 8'd100) begin failures++; $display("FAIL dmg_early_commit got=%0d exp=100", ai_hp); end
        p_req = 1'b0;
        step();
        checks++; if (ai_hp !== 8'd70) begin failures++; $display("FAIL dmg_ai_hp got=%0d exp=70", ai_hp); end
        checks++; if ({busy, p_ack} !== 2'b00) begin failures++; $display("FAIL dmg_idle busy,ack got=%b exp=00", {busy, p_ack}); end
        checks++; if (p_hp !== 8'd100) begin failures++; $display("FAIL dmg_p_hp got=%0d exp=100", p_hp); end
    endtask

    task automatic test_saturation();
        bit acked;
        run_op(1'b0, 1'b0, 8'd60, acked);
        checks++; if (ai_hp !== 8'd10) begin failures++; $display("FAIL sat_pre got=%0d exp=10", ai_hp); end
        run_op(1'b0, 1'b0, 8'd25, acked);
        checks++; if (!acked) begin failures++; $display("FAIL sat_ack got=0 exp=1"); end
        checks++; if (ai_hp !== 8'd0) begin failures++; $display("FAIL sat_ai_hp got=%0d exp=0", ai_hp); end
        checks++; if ({ai_dead, p_dead, busy} !== 3'b101) begin failures++; $display("FAIL sat_halt dead,pdead,busy got=%b exp=101", {ai_dead, p_dead, busy}); end
        run_op(1'b1, 1'b0, 8'd5, acked);
        checks++; if (acked) begin failures++; $display("FAIL halt_no_ack got=1 exp=0"); end
        checks++; if (p_hp !== 8'd100) begin failures++; $display("FAIL halt_p_hp got=%0d exp=100", p_hp); end
        checks++; if (busy !== 1'b1) begin failures++; $display("FAIL halt_busy got=%b exp=1", busy); end
        load_hp = 1'b1;
        step();
        load_hp = 1'b0;
        checks++; if ({ai_hp, p_hp} !== {8'd100, 8'd100}) begin failures++; $display("FAIL halt_load_hp got=%0d/%0d exp=100/100", p_hp, ai_hp); end
        checks++; if ({ai_dead, p_dead, busy} !== 3'b000) begin failures++; $display("FAIL halt_load_flags got=%b exp=000", {ai_dead, p_dead, busy}); end
    endtask

    task automatic test_heal_clamp();
        bit acked;
        run_op(1'b1, 1'b0, 8'd10, acked);
        checks++; if (p_hp !== 8'd90) begin failures++; $display("FAIL heal_pre got=%0d exp=90", p_hp); end
        run_op(1'b1, 1'b0, 8'd0, acked);
        checks++; if (!acked || p_hp !== 8'd90) begin failures++; $display("FAIL dmg_zero ack=%0d hp=%0d exp ack=1 hp=90", acked, p_hp); end
        run_op(1'b0, 1'b1, 8'd50, acked);
        checks++; if (p_hp !== 8'd100) begin failures++; $display("FAIL heal_clamp got=%0d exp=100", p_hp); end
        run_op(1'b0, 1'b1, 8'd0, acked);
        checks++; if (!acked || p_hp !== 8'd100) begin failures++; $display("FAIL heal_zero ack=%0d hp=%0d exp ack=1 hp=100", acked, p_hp); end
        run_op(1'b0, 1'b0, 8'd30, acked);
        run_op(1'b1, 1'b1, 8'd20, acked);
        checks++; if (ai_hp !== 8'd90) begin failures++; $display("FAIL ai_heal got=%0d exp=90", ai_hp); end
        run_op(1'b1, 1'b1, 8'd200, acked);
        checks++; if (ai_hp !== 8'd100) begin failures++; $display("FAIL ai_heal_clamp got=%0d exp=100", ai_hp); end
    endtask

    task automatic test_tie();
        logic [9:0] exp_p, exp_ai;
        exp_p  = 10'b01_0000_0100;
        exp_ai = 10'b00_0010_0000;
        reset = 1'b1;
        p_req = 1'b1; p_op = 1'b0; p_amt = 8'd5;
        ai_req = 1'b1; ai_op = 1'b0; ai_amt = 8'd7;
        step();
        reset = 1'b0;
        for (int c = 0; c < 10; c++) begin
            checks++; if (p_ack !== exp_p[c])  begin failures++; $display("FAIL tie_p_ack cyc=%0d got=%b exp=%b", c, p_ack, exp_p[c]); end
            checks++; if (ai_ack !== exp_ai[c]) begin failures++; $display("FAIL tie_ai_ack cyc=%0d got=%b exp=%b", c, ai_ack, exp_ai[c]); end
            if (c == 9) begin
                p_req = 1'b0;
                ai_req = 1'b0;
            end else begin
                step();
            end
        end
        checks++; if ({p_hp, ai_hp} !== {8'd93, 8'd90}) begin failures++; $display("FAIL tie_hp got=%0d/%0d exp=93/90", p_hp, ai_hp); end
        step();
    endtask

    task automatic test_load_abort();
        p_req = 1'b1; p_op = 1'b0; p_amt = 8'd40;
        step();
        checks++; if (busy !== 1'b1) begin failures++; $display("FAIL abort_calc busy got=%b exp=1", busy); end
        load_hp = 1'b1;
        p_req = 1'b0;
        step();
        load_hp = 1'b0;
        checks++; if ({busy, p_ack, ai_ack} !== 3'b000) begin failures++; $display("FAIL abort_idle busy,acks got=%b exp=000", {busy, p_ack, ai_ack}); end
        checks++; if ({p_hp, ai_hp} !== {8'd100, 8'd100}) begin failures++; $display("FAIL abort_hp got=%0d/%0d exp=100/100", p_hp, ai_hp); end
        for (int i = 0; i < 3; i++) begin
            step();
            checks++; if ({p_ack, ai_ack, ai_hp} !== {2'b00, 8'd100}) begin failures++; $display("FAIL abort_after cyc=%0d acks=%b ai_hp=%0d exp acks=00 ai_hp=100", i, {p_ack, ai_ack}, ai_hp); end
        end
    endtask

    task automatic test_async_reset();
        bit acked;
        run_op(1'b0, 1'b0, 8'd20, acked);
        checks++; if (ai_hp !== 8'd80) begin failures++; $display("FAIL ar_pre got=%0d exp=80", ai_hp); end
        p_req = 1'b1; p_op = 1'b0; p_amt = 8'd20;
        step();
        step();
        checks++; if (p_ack !== 1'b1) begin failures++; $display("FAIL ar_write_ack got=%b exp=1", p_ack); end
        #2;
        reset = 1'b1;
        #1;
        checks++; if ({p_ack, busy} !== 2'b00) begin failures++; $display("FAIL ar_ack_drop ack,busy got=%b exp=00", {p_ack, busy}); end
        checks++; if (ai_hp !== 8'd100) begin failures++; $display("FAIL ar_ai_hp got=%0d exp=100", ai_hp); end
        p_req = 1'b0;
        step();
        reset = 1'b0;
        step();
        checks++; if ({busy, ai_hp} !== {1'b0, 8'd100}) begin failures++; $display("FAIL ar_after busy=%b ai_hp=%0d exp busy=0 ai_hp=100", busy, ai_hp); end
    endtask

    initial begin
        test_reset();
        test_damage();
        test_saturation();
        test_heal_clamp();
        test_tie();
        test_load_abort();
        test_async_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/hp_arbiter_seq.md
# hp_arbiter_seq

Hit-point update sequencer that sits between the battle control FSM and the two trainers' action logic. It arbitrates damage and heal requests from the player and AI requesters. Each granted request runs as a saturating read-modify-write on the two HP registers, with registered HP outputs and registered faint flags (`p_dead`, `ai_dead`). The battle control FSM consumes the faint flags directly.

## Interface
Parameters:
- `HP_W`, 8: HP and amount width in bits.
- `P_MAX_HP`, 100: player Pokémon full HP; must be 1..2^HP_W−1.
- `AI_MAX_HP`, 100: AI Pokémon full HP; must be 1..2^HP_W−1.

Ports:
- `clk`, in, 1: single clock, rising edge.
- `reset`, in, 1: asynchronous, active-high reset.
- `load_hp`, in, 1: sync restore of both HP to max; clears faint flags.
- `p_req`, in, 1: player requester valid, level-held until `p_ack`.
- `p_op`, in, 1: player op; 0 = damage the AI, 1 = heal the player.
- `p_amt`, in, HP_W: player amount.
- `p_ack`, out, 1: one-cycle completion pulse to the player.
- `ai_req`, in, 1: AI requester valid, level-held until `ai_ack`.
- `ai_op`, in, 1: AI op; 0 = damage the player, 1 = heal the AI.
- `ai_amt`, in, HP_W: AI amount.
- `ai_ack`, out, 1: one-cycle completion pulse to the AI.
- `p_hp`, out, HP_W: player HP register.
- `ai_hp`, out, HP_W: AI HP register.
- `p_dead`, out, 1: player HP reached 0.
- `ai_dead`, out, 1: AI HP reached 0.
- `busy`, out, 1: high in any state other than IDLE.

## Operation
- States and transitions:
  - IDLE: arbitrate; if any eligible request, latch the winner and go to CALC.
  - CALC: compute the new value into a holding register; go to WRITE.
  - WRITE: commit, pulse the ack; go to IDLE, or to HALT if either dead flag becomes 1.
  - HALT: ignore all requests, no acks; leave only via `load_hp` or `reset`.
- Arbitration, round-robin:
  - A single requester wins outright.
  - If both request in the same IDLE cycle, the one not granted last wins.
  - `last_grant` updates only on WRITE.
- Operand latch: op, amt, and requester id are captured on the IDLE→CALC edge. Input changes after that edge have no effect.
- Damage: the target is the opponent's HP.
  - new = old − amt if amt < old, else 0.
  - Compute at HP_W+1 bits; no wrap.
- Heal: the target is the requester's own HP.
  - new = min(old + amt, MAX).
  - Compute at HP_W+1 bits so the sum never wraps.
- amt = 0 is a legal request: full 3-cycle sequence and ack, HP unchanged.
- Dead flags:
  - Set on the WRITE edge when the written HP equals 0.
  - Never cleared except by `load_hp` or `reset`.
  - Heal of a HP-0 target cannot occur, because HALT blocks it.
- `load_hp` has highest priority, from any state:
  - Aborts an in-flight op; no ack is issued and the HP write is dropped.
  - Sets `p_hp`=P_MAX_HP, `ai_hp`=AI_MAX_HP, both dead flags to 0, and returns to IDLE.
  - `last_grant` is unchanged.
- Reset values:
  - `p_hp`=P_MAX_HP, `ai_hp`=AI_MAX_HP.
  - `p_dead`=0, `ai_dead`=0, `p_ack`=0, `ai_ack`=0, `busy`=0.
  - State = IDLE, `last_grant` = AI, so the player wins the first tie.

## Timing
- Request sampled in IDLE at edge N:
  - CALC during cycle N+1.
  - WRITE during cycle N+2.
  - Ack is high for exactly cycle N+2, decoded from state and the latched id.
  - HP and dead flags update on edge N+3.
  - Back in IDLE (or HALT) from N+3.
- Minimum spacing between grants is 3 cycles. Back-to-back throughput is 1 op per 3 cycles.
- Requesters drop `req` at the edge where they see `ack`. A `req` still high in the following IDLE cycle is treated as a new request.
- `busy` is combinational from state: 1 in CALC, WRITE and HALT.
- Asynchronous `reset` asserted mid-operation: immediate return to reset values; no ack.

## Test plan
- Player damage:
  - Reset, `p_req`=1, `p_op`=0, `p_amt`=30.
  - `p_ack` is high 2 cycles after sampling; `ai_hp`=70 the next cycle; `busy` is 1 for 2 cycles before it.
- Saturation:
  - `ai_hp`=10, damage 25 → `ai_hp`=0, `ai_dead`=1, state HALT.
  - A subsequent `ai_req` gets no `ai_ack`.
- Heal clamp:
  - `p_hp`=90, AI damage 0 then player heal 50 → `p_hp`=100.
  - Heal 0 at full HP → ack issued, `p_hp`=100.
- Tie arbitration:
  - Both requests held continuously from reset → grants alternate player, AI, player.
  - Acks fall on cycles 2, 5, 8.
- `load_hp` abort:
  - Assert `load_hp` during CALC of a 40-damage op.
  - No ack; HP both 100; dead flags 0; IDLE next cycle.
  - Same check from HALT.
- Async reset:
  - Assert `reset` mid-WRITE between clock edges.
  - Ack drops immediately; HP = max, with no clock edge needed.
